// File: rtl/btn_rst_cond_if.sv
// Button/reset conditioner bus: raw pins in, conditioned levels, event pulses
// and the stretched system reset out.
interface btn_rst_cond_if #(
    parameter int unsigned NUM_BTN = 1
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;
    logic               sys_rst;
    logic               ready;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_long, sys_rst, ready
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_long, sys_rst, ready
    );
endinterface

// File: rtl/btn_rst_cond.sv
// Per-channel synchronise/debounce/long-press detection plus a stretched system
// reset that a long press on channel 0 can retrigger.
module btn_rst_cond #(
    parameter int unsigned NUM_BTN           = 1,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES   = 32,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1,
    parameter bit          LONG_RST_EN       = 1'b1
) (
    input logic           clk,
    input logic           rst,
    btn_rst_cond_if.slave bus
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int unsigned HW = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DLast  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LMax   = LW'(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LPen   = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HLoad  = HW'(RST_HOLD_CYCLES);
    localparam logic          RelLvl = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {StIdle, StDebPress, StPressed, StDebRelease} state_e;

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] level_vec, press_vec, release_vec, long_vec, long_evt;

    // Reset loads the released level so a held button must be re-debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {NUM_BTN{RelLvl}};
            end
        end else begin
            sync_q[0] <= bus.btn_raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign pressed = BTN_ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_e        state_q, state_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [LW-1:0] lcnt_q, lcnt_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          level_c, press_c, release_c, long_c;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= StIdle;
                dcnt_q    <= '0;
                lcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                lcnt_q    <= lcnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            dcnt_d    = dcnt_q;
            lcnt_d    = lcnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                StIdle: begin
                    if (pressed[g]) begin
                        state_d = StDebPress;
                        dcnt_d  = '0;
                    end
                end
                StDebPress: begin
                    if (!pressed[g]) begin
                        state_d = StIdle;
                    end else if (dcnt_q == DLast) begin
                        state_d = StPressed;
                        lcnt_d  = '0;
                        press_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!pressed[g]) begin
                        state_d = StDebRelease;
                        dcnt_d  = '0;
                    end else if (lcnt_q != LMax) begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
                StDebRelease: begin
                    // A bounce back to pressed keeps the long-press count intact.
                    if (pressed[g]) begin
                        state_d = StPressed;
                    end else if (dcnt_q == DLast) begin
                        state_d   = StIdle;
                        release_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            long_d = (lcnt_q == LPen) && (lcnt_d == LMax);
        end

        always_comb begin
            level_c   = ((state_q == StPressed) || (state_q == StDebRelease)) && !rst;
            press_c   = press_q && !rst;
            release_c = release_q && !rst;
            long_c    = long_q && !rst;
        end

        assign level_vec[g]   = level_c;
        assign press_vec[g]   = press_c;
        assign release_vec[g] = release_c;
        assign long_vec[g]    = long_c;
        assign long_evt[g]    = long_d;
    end

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_rst;

    // Reload on the same edge that raises btn_long so sys_rst rises with the pulse.
    assign long_rst = LONG_RST_EN && long_evt[0];

    always_comb begin
        hcnt_d = hcnt_q;
        if (long_rst) begin
            hcnt_d = HLoad;
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= HLoad;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_press   = press_vec;
    assign bus.btn_release = release_vec;
    assign bus.btn_long    = long_vec;
    assign bus.sys_rst     = rst | (hcnt_q != '0);
    assign bus.ready       = ~bus.sys_rst;
endmodule

// File: tb/tb_btn_rst_cond.sv
// Directed bench for btn_rst_cond: reset stretch, debounce, bounce, long press,
// release glitch and mid-debounce reset on a 3-channel instance.
module tb_btn_rst_cond;
    localparam int unsigned NB = 3;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    int press_cnt [NB];
    int press_edge[NB];
    int rel_cnt   [NB];
    int rel_edge  [NB];
    int long_cnt  [NB];
    int long_edge [NB];
    int rst_hi;
    int rst_edge;
    int cnt;

    always #5 clk = ~clk;

    btn_rst_cond_if #(.NUM_BTN(NB)) bif ();

    btn_rst_cond #(
        .NUM_BTN          (NB),
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(64),
        .RST_HOLD_CYCLES  (32),
        .BTN_ACTIVE_LOW   (1'b1),
        .LONG_RST_EN      (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rec();
        for (int c = 0; c < NB; c++) begin
            press_cnt[c] = 0; press_edge[c] = -1;
            rel_cnt[c]   = 0; rel_edge[c]   = -1;
            long_cnt[c]  = 0; long_edge[c]  = -1;
        end
        rst_hi   = 0;
        rst_edge = -1;
    endtask

    task automatic sample(input int e);
        for (int c = 0; c < NB; c++) begin
            if (bif.btn_press[c]) begin
                press_cnt[c]++;
                if (press_edge[c] < 0) press_edge[c] = e;
            end
            if (bif.btn_release[c]) begin
                rel_cnt[c]++;
                if (rel_edge[c] < 0) rel_edge[c] = e;
            end
            if (bif.btn_long[c]) begin
                long_cnt[c]++;
                if (long_edge[c] < 0) long_edge[c] = e;
            end
        end
        if (bif.sys_rst) begin
            rst_hi++;
            if (rst_edge < 0) rst_edge = e;
        end
    endtask

    initial begin
        rst         = 1'b1;
        bif.btn_raw = 3'b111;
        repeat (3) next_edge();

        // Reset state and stretch
        check_eq("rst_level", int'(bif.btn_level), 0);
        check_eq("rst_pulses", int'({bif.btn_press, bif.btn_release, bif.btn_long}), 0);
        check_eq("rst_sys_rst", int'(bif.sys_rst), 1);
        check_eq("rst_ready", int'(bif.ready), 0);
        rst = 1'b0;
        #1;
        check_eq("stretch_first", int'(bif.sys_rst), 1);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            next_edge();
            if (!bif.sys_rst) break;
            cnt++;
        end
        check_eq("stretch_len", cnt, 32);
        check_eq("stretch_ready", int'(bif.ready), 1);

        // ch0 clean press + long press; ch2 press with a 2-cycle release glitch
        clear_rec();
        bif.btn_raw = 3'b010;
        for (int e = 1; e <= 110; e++) begin
            next_edge();
            sample(e);
            if (e == 6)  check_eq("level0_e6", int'(bif.btn_level[0]), 0);
            if (e == 7)  check_eq("level0_e7", int'(bif.btn_level[0]), 1);
            if (e == 13) check_eq("level2_glitch", int'(bif.btn_level[2]), 1);
            if (e == 70) check_eq("sysrst_e70", int'(bif.sys_rst), 0);
            if (e == 9)  bif.btn_raw[2] = 1'b1;
            if (e == 11) bif.btn_raw[2] = 1'b0;
        end
        check_eq("press0_edge", press_edge[0], 7);
        check_eq("press0_cnt", press_cnt[0], 1);
        check_eq("press1_cnt", press_cnt[1], 0);
        check_eq("press2_edge", press_edge[2], 7);
        check_eq("press2_cnt", press_cnt[2], 1);
        check_eq("glitch_rel2", rel_cnt[2], 0);
        check_eq("long0_edge", long_edge[0], 71);
        check_eq("long0_cnt", long_cnt[0], 1);
        check_eq("long2_edge", long_edge[2], 74);
        check_eq("long2_cnt", long_cnt[2], 1);
        check_eq("longrst_edge", rst_edge, 71);
        check_eq("longrst_len", rst_hi, 32);

        // Release ch0 and ch2
        clear_rec();
        bif.btn_raw = 3'b111;
        for (int e = 1; e <= 12; e++) begin
            next_edge();
            sample(e);
            if (e == 6) check_eq("level0_rel_e6", int'(bif.btn_level[0]), 1);
            if (e == 7) check_eq("level0_rel_e7", int'(bif.btn_level[0]), 0);
        end
        check_eq("rel0_edge", rel_edge[0], 7);
        check_eq("rel0_cnt", rel_cnt[0], 1);
        check_eq("rel2_edge", rel_edge[2], 7);
        check_eq("rel_press_cnt", press_cnt[0] + press_cnt[2], 0);

        // ch1 bounce: toggles every 2 cycles for 20 cycles, then held pressed
        clear_rec();
        for (int e = 1; e <= 40; e++) begin
            bif.btn_raw[1] = (e <= 20) ? (((e - 1) / 2) % 2 != 0) : 1'b0;
            next_edge();
            sample(e);
        end
        check_eq("bounce_edge", press_edge[1], 27);
        check_eq("bounce_cnt", press_cnt[1], 1);
        check_eq("bounce_rel", rel_cnt[1], 0);
        check_eq("bounce_other", press_cnt[0] + press_cnt[2], 0);

        clear_rec();
        bif.btn_raw = 3'b111;
        for (int e = 1; e <= 12; e++) begin
            next_edge();
            sample(e);
        end
        check_eq("rel1_edge", rel_edge[1], 7);

        // ch1 press interrupted by rst at dcnt=2; held button is re-debounced
        clear_rec();
        bif.btn_raw[1] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            next_edge();
            sample(e);
            if (e == 5) rst = 1'b1;
            if (e == 6) begin
                check_eq("midrst_level", int'(bif.btn_level), 0);
                check_eq("midrst_ready", int'(bif.ready), 0);
                rst = 1'b0;
            end
            if (e == 12) check_eq("midrst_lvl1_e12", int'(bif.btn_level[1]), 0);
            if (e == 13) check_eq("midrst_lvl1_e13", int'(bif.btn_level[1]), 1);
        end
        check_eq("midrst_press1_edge", press_edge[1], 13);
        check_eq("midrst_press1_cnt", press_cnt[1], 1);
        check_eq("midrst_other_press", press_cnt[0] + press_cnt[2], 0);
        check_eq("midrst_rel", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 0);
        check_eq("midrst_long", long_cnt[0] + long_cnt[1] + long_cnt[2], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
